// File: rtl/prm_scan_pkg.sv
// Shared definitions for the PRM edge-scan controller: FSM encoding, defaults
// and elaboration-time sizing helpers.
package prm_scan_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_EMIT  = 2'd3;

    localparam int CODE_W_DEF = 15;

    // Minimum of 1 so a 1-wide word still gets a legal index signal.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int word_count(input int edges, input int w);
        return (edges + w - 1) / w;
    endfunction

endpackage

// File: rtl/prm_mask_pack.sv
// Aligns checker returns with their issue slot through a CHK_LAT-deep
// valid/bit-index delay line and packs them into one OUT_W-bit result word.
module prm_mask_pack #(
    parameter int OUT_W   = 32,
    parameter int CHK_LAT = 1,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             cap_vld,
    input  logic [IDX_W-1:0] cap_idx,
    input  logic             mask,
    output logic             hit,
    output logic [OUT_W-1:0] word
);

    logic [CHK_LAT:0]            vld_pipe;
    logic [CHK_LAT:0][IDX_W-1:0] idx_pipe;

    generate
        if (CHK_LAT == 0) begin : g_comb
            assign vld_pipe = cap_vld;
            assign idx_pipe = cap_idx;
        end else begin : g_dly
            logic [CHK_LAT-1:0]            vld_sr;
            logic [CHK_LAT-1:0][IDX_W-1:0] idx_sr;

            // clear also flushes in-flight returns so an aborted scan leaves nothing behind
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_sr <= '0;
                    idx_sr <= '0;
                end else if (clear) begin
                    vld_sr <= '0;
                    idx_sr <= '0;
                end else begin
                    vld_sr <= vld_pipe[CHK_LAT-1:0];
                    idx_sr <= idx_pipe[CHK_LAT-1:0];
                end
            end

            assign vld_pipe = {vld_sr, cap_vld};
            assign idx_pipe = {idx_sr, cap_idx};
        end
    endgenerate

    assign hit = vld_pipe[CHK_LAT] & mask & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (clear) begin
            word <= '0;
        end else if (vld_pipe[CHK_LAT]) begin
            word[idx_pipe[CHK_LAT]] <= mask;
        end
    end

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Walks every roadmap edge through the shared checker port and streams packed
// edge masks to the planner. PRM_SCAN_CNT_EN adds the blk_cnt blocked-edge count.
module prm_edge_scan_ctrl
    import prm_scan_pkg::*;
#(
    parameter int NUM_EDGES = 256,
    parameter int EDGE_W    = 8,
    parameter int CODE_W    = CODE_W_DEF,
    parameter int OUT_W     = 32,
    parameter int CHK_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CODE_W-1:0] req_code,
    input  logic              abort,
    output logic              chk_valid,
    output logic [EDGE_W-1:0] chk_edge,
    output logic [CODE_W-1:0] chk_code,
    input  logic              chk_mask,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_word,
    output logic [EDGE_W-1:0] res_idx,
    output logic              res_last,
`ifdef PRM_SCAN_CNT_EN
    output logic [EDGE_W:0]   blk_cnt,
`endif
    output logic              busy
);

    localparam int IDX_W     = clog2_min1(OUT_W);
    localparam int NUM_WORDS = word_count(NUM_EDGES, OUT_W);

    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(NUM_EDGES - 1);
    localparam logic [EDGE_W-1:0] LAST_WORD = EDGE_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(OUT_W - 1);
    localparam logic [2:0]        DRAIN_END = 3'(CHK_LAT - 1);

    logic [1:0]        state, state_nx;
    logic [EDGE_W-1:0] edge_cnt;
    logic [IDX_W-1:0]  bit_cnt;
    logic [EDGE_W-1:0] word_cnt;
    logic [2:0]        drain_cnt;
    logic [CODE_W-1:0] code_q;
    logic [OUT_W-1:0]  word;
    logic              hit;

    logic req_hs, res_hs, last_issue, drain_done, last_word, pack_clear;

    assign req_hs     = (state == S_IDLE) & req_valid;
    assign res_hs     = (state == S_EMIT) & res_ready;
    assign last_issue = (state == S_SCAN) & ((bit_cnt == LAST_BIT) | (edge_cnt == LAST_EDGE));
    assign drain_done = (drain_cnt == DRAIN_END);
    assign last_word  = (word_cnt == LAST_WORD);
    assign pack_clear = abort | req_hs | res_hs;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_valid) state_nx = S_SCAN;
            S_SCAN: begin
                if (last_issue) begin
                    if (CHK_LAT == 0) state_nx = S_EMIT;
                    else              state_nx = S_DRAIN;
                end
            end
            S_DRAIN: if (drain_done) state_nx = S_EMIT;
            S_EMIT: begin
                if (res_ready) state_nx = last_word ? S_IDLE : S_SCAN;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Each word's scan starts on an OUT_W boundary, so bit_cnt doubles as edge mod OUT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            drain_cnt <= '0;
            code_q    <= '0;
        end else if (abort) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            drain_cnt <= '0;
            code_q    <= '0;
        end else begin
            if (req_hs) begin
                code_q   <= req_code;
                edge_cnt <= '0;
                bit_cnt  <= '0;
                word_cnt <= '0;
            end
            if (state == S_SCAN) begin
                bit_cnt <= last_issue ? '0 : bit_cnt + 1'b1;
                if (edge_cnt != LAST_EDGE) edge_cnt <= edge_cnt + 1'b1;
            end
            if (state == S_DRAIN) drain_cnt <= drain_done ? '0 : drain_cnt + 1'b1;
            if (res_hs && !last_word) word_cnt <= word_cnt + 1'b1;
        end
    end

    prm_mask_pack #(
        .OUT_W   (OUT_W),
        .CHK_LAT (CHK_LAT),
        .IDX_W   (IDX_W)
    ) u_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (pack_clear),
        .cap_vld (chk_valid),
        .cap_idx (bit_cnt),
        .mask    (chk_mask),
        .hit     (hit),
        .word    (word)
    );

`ifdef PRM_SCAN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                blk_cnt <= '0;
        else if (abort || req_hs)  blk_cnt <= '0;
        else if (hit)              blk_cnt <= blk_cnt + 1'b1;
    end
`endif

    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;
    assign chk_valid = (state == S_SCAN);
    assign chk_edge  = chk_valid ? edge_cnt : '0;
    assign chk_code  = code_q;
    assign res_valid = (state == S_EMIT);
    assign res_word  = res_valid ? word : '0;
    assign res_idx   = res_valid ? word_cnt : '0;
    assign res_last  = res_valid & last_word;

endmodule
